// File: rtl/arb2_mux_ctrl.sv
// Two-requester round-robin arbiter driving a registered 2:1 data mux.
// Optional ARB_LOCK_EN adds a lock input that suppresses grant expiry.
module arb2_mux_ctrl #(
  parameter int WIDTH = 8,
  parameter int HOLD  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  output logic [1:0]       gnt,
  output logic             sel,
  output logic [WIDTH-1:0] y,
  output logic             vld
`ifdef ARB_LOCK_EN
  ,input logic             lock
`endif
);

  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, G0 = 2'd1, G1 = 2'd2} state_t;

  state_t          state;
  logic            ptr;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;
  logic            cur, own_req, oth_req, xfer, at_max, lock_hold;
  logic            go, go_k, go_idle;

  assign cur     = (state == G1);
  assign own_req = req[cur];
  assign oth_req = req[~cur];
  assign xfer    = |(gnt & req);
  assign at_max  = (cnt == CW'(HOLD - 1));

`ifdef ARB_LOCK_EN
  assign lock_hold = lock;
`else
  assign lock_hold = 1'b0;
`endif

  // Next-grant decision; go/go_k request entry into G(go_k), go_idle a return to IDLE.
  always_comb begin
    go      = 1'b0;
    go_k    = 1'b0;
    go_idle = 1'b0;
    cnt_nxt = cnt;
    if (state == IDLE) begin
      if (|req) begin
        go   = 1'b1;
        go_k = (req == 2'b11) ? ptr : req[1];
      end
    end else if (!own_req) begin
      if (oth_req) begin
        go   = 1'b1;
        go_k = ~cur;
      end else begin
        go_idle = 1'b1;
      end
    end else if (at_max && !lock_hold) begin
      // Expiry: hand over under contention, otherwise start a fresh window.
      if (oth_req) begin
        go   = 1'b1;
        go_k = ~cur;
      end else begin
        cnt_nxt = '0;
      end
    end else if (!at_max) begin
      cnt_nxt = cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= 2'b00;
      sel   <= 1'b0;
      y     <= '0;
      vld   <= 1'b0;
      ptr   <= 1'b0;
      cnt   <= '0;
    end else begin
      vld <= xfer;
      if (xfer) y <= gnt[1] ? d1 : d0;
      if (go) begin
        state <= go_k ? G1 : G0;
        gnt   <= go_k ? 2'b10 : 2'b01;
        sel   <= go_k;
        ptr   <= ~go_k;
        cnt   <= '0;
      end else if (go_idle) begin
        state <= IDLE;
        gnt   <= 2'b00;
        cnt   <= '0;
      end else begin
        cnt <= cnt_nxt;
      end
    end
  end

endmodule

// File: tb/tb_arb2_mux_ctrl.sv
// Directed bench for arb2_mux_ctrl: HOLD=4 main instance plus a HOLD=1 instance.
module tb_arb2_mux_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req = 2'b00;
  logic [7:0] d0  = 8'h00;
  logic [7:0] d1  = 8'h00;
`ifdef ARB_LOCK_EN
  logic       lock = 1'b0;
`endif

  logic [1:0] gnt_a, gnt_b;
  logic       sel_a, sel_b, vld_a, vld_b;
  logic [7:0] y_a, y_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  arb2_mux_ctrl #(.WIDTH(8), .HOLD(4)) u_dut (
    .clk(clk), .rst(rst), .req(req), .d0(d0), .d1(d1),
    .gnt(gnt_a), .sel(sel_a), .y(y_a), .vld(vld_a)
`ifdef ARB_LOCK_EN
    ,.lock(lock)
`endif
  );

  arb2_mux_ctrl #(.WIDTH(8), .HOLD(1)) u_h1 (
    .clk(clk), .rst(rst), .req(req), .d0(d0), .d1(d1),
    .gnt(gnt_b), .sel(sel_b), .y(y_b), .vld(vld_b)
`ifdef ARB_LOCK_EN
    ,.lock(lock)
`endif
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    req = 2'b00;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    n_tests++;
    if ({gnt_a, sel_a, y_a, vld_a} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_init got gnt=%b sel=%b y=%h vld=%b exp 00/0/00/0", gnt_a, sel_a, y_a, vld_a);
    end
    // Reach G1 with a live transfer, then reset mid-grant.
    d1  = 8'h5C;
    req = 2'b10;
    step();
    step();
    n_tests++;
    if (gnt_a !== 2'b10 || vld_a !== 1'b1 || y_a !== 8'h5C) begin
      n_fail++;
      $display("FAIL reset_pre got gnt=%b vld=%b y=%h exp 10/1/5c", gnt_a, vld_a, y_a);
    end
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_tests++;
      if ({gnt_a, sel_a, y_a, vld_a} !== 12'h000) begin
        n_fail++;
        $display("FAIL reset_mid c=%0d got gnt=%b sel=%b y=%h vld=%b exp 00/0/00/0", i, gnt_a, sel_a, y_a, vld_a);
      end
    end
    rst = 1'b0;
    req = 2'b11;
    step();
    n_tests++;
    if (gnt_a !== 2'b01 || sel_a !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ptr got gnt=%b sel=%b exp 01/0", gnt_a, sel_a);
    end
  endtask

  task automatic test_single;
    do_reset();
    d0  = 8'hA5;
    req = 2'b01;
    step();
    n_tests++;
    if (gnt_a !== 2'b01 || vld_a !== 1'b0) begin
      n_fail++;
      $display("FAIL single_lat got gnt=%b vld=%b exp 01/0", gnt_a, vld_a);
    end
    for (int e = 2; e <= 10; e++) begin
      step();
      n_tests++;
      if (gnt_a !== 2'b01 || vld_a !== 1'b1 || y_a !== 8'hA5) begin
        n_fail++;
        $display("FAIL single e=%0d got gnt=%b vld=%b y=%h exp 01/1/a5", e, gnt_a, vld_a, y_a);
      end
    end
  endtask

  task automatic test_contention;
    logic [1:0] eg;
    logic [7:0] ey;
    do_reset();
    d0  = 8'h11;
    d1  = 8'h22;
    req = 2'b11;
    for (int e = 1; e <= 13; e++) begin
      step();
      eg = (((e - 1) / 4) % 2 == 0) ? 2'b01 : 2'b10;
      n_tests++;
      if (gnt_a !== eg) begin
        n_fail++;
        $display("FAIL contention_gnt e=%0d got %b exp %b", e, gnt_a, eg);
      end
      if (e >= 2) begin
        ey = (((e - 2) / 4) % 2 == 0) ? 8'h11 : 8'h22;
        n_tests++;
        if (vld_a !== 1'b1 || y_a !== ey) begin
          n_fail++;
          $display("FAIL contention_y e=%0d got vld=%b y=%h exp 1/%h", e, vld_a, y_a, ey);
        end
      end
    end
  endtask

  task automatic test_drop;
    do_reset();
    d0  = 8'h11;
    d1  = 8'h22;
    req = 2'b11;
    step();
    step();
    step();
    n_tests++;
    if (gnt_a !== 2'b01 || vld_a !== 1'b1 || y_a !== 8'h11) begin
      n_fail++;
      $display("FAIL drop_pre got gnt=%b vld=%b y=%h exp 01/1/11", gnt_a, vld_a, y_a);
    end
    req = 2'b10;
    step();
    n_tests++;
    if (gnt_a !== 2'b10 || vld_a !== 1'b0 || y_a !== 8'h11 || sel_a !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_bubble got gnt=%b vld=%b y=%h sel=%b exp 10/0/11/1", gnt_a, vld_a, y_a, sel_a);
    end
    step();
    n_tests++;
    if (gnt_a !== 2'b10 || vld_a !== 1'b1 || y_a !== 8'h22) begin
      n_fail++;
      $display("FAIL drop_new got gnt=%b vld=%b y=%h exp 10/1/22", gnt_a, vld_a, y_a);
    end
    req = 2'b00;
    step();
    n_tests++;
    if (gnt_a !== 2'b00 || vld_a !== 1'b0 || sel_a !== 1'b1 || y_a !== 8'h22) begin
      n_fail++;
      $display("FAIL drop_idle got gnt=%b vld=%b sel=%b y=%h exp 00/0/1/22", gnt_a, vld_a, sel_a, y_a);
    end
  endtask

  task automatic test_hold1;
    logic [1:0] eg;
    logic [7:0] ey;
    do_reset();
    d0  = 8'h11;
    d1  = 8'h22;
    req = 2'b11;
    for (int e = 1; e <= 8; e++) begin
      step();
      eg = (e % 2 == 1) ? 2'b01 : 2'b10;
      n_tests++;
      if (gnt_b !== eg) begin
        n_fail++;
        $display("FAIL hold1_gnt e=%0d got %b exp %b", e, gnt_b, eg);
      end
      if (e >= 2) begin
        ey = (e % 2 == 0) ? 8'h11 : 8'h22;
        n_tests++;
        if (vld_b !== 1'b1 || y_b !== ey) begin
          n_fail++;
          $display("FAIL hold1_y e=%0d got vld=%b y=%h exp 1/%h", e, vld_b, y_b, ey);
        end
      end
    end
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock;
    do_reset();
    d0   = 8'h11;
    d1   = 8'h22;
    lock = 1'b1;
    req  = 2'b11;
    for (int e = 1; e <= 11; e++) begin
      step();
      n_tests++;
      if (gnt_a !== 2'b01) begin
        n_fail++;
        $display("FAIL lock_hold e=%0d got %b exp 01", e, gnt_a);
      end
    end
    lock = 1'b0;
    step();
    n_tests++;
    if (gnt_a !== 2'b10 || vld_a !== 1'b1 || y_a !== 8'h11) begin
      n_fail++;
      $display("FAIL lock_release got gnt=%b vld=%b y=%h exp 10/1/11", gnt_a, vld_a, y_a);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_drop();
    test_hold1();
`ifdef ARB_LOCK_EN
    test_lock();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
